// File: rtl/tx_gb_pkg.sv
// -----------------------------------------------------------------------------
// tx_gb_pkg
// Shared constants and types for the TX 66:64 gearbox and its scrambler.
// -----------------------------------------------------------------------------
package tx_gb_pkg;

    localparam int BLK_W     = 66;
    localparam int WORD_W    = 64;
    localparam int SCR_W     = 58;
    localparam int SCR_TAP_A = 39;
    localparam int SCR_TAP_B = 58;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam logic [SCR_W-1:0] SCR_SEED_DEF = 58'h3FF_FFFF_FFFF_FFFF;

    // Gearbox fill count spans 0..64 in steps of 2.
    localparam int              FILL_W    = 7;
    localparam logic [FILL_W-1:0] FILL_FULL = 7'd64;

    // Packed so that the header occupies bits 1:0 and the payload bits 65:2,
    // which is the on-wire order (bit 0 transmitted first).
    typedef struct packed {
        logic [WORD_W-1:0] dat;
        logic [1:0]        sh;
    } blk66_t;

    // What the gearbox does in a given cycle.
    typedef enum logic [1:0] {
        GB_PUSH     = 2'd0,  // block accepted, one word out
        GB_FLUSH    = 2'd1,  // no block, full residue emitted
        GB_OVERRUN  = 2'd2,  // block arrived while full: dropped, residue emitted
        GB_UNDERRUN = 2'd3   // no block and residue too short: no output
    } gb_op_e;

endpackage

// File: rtl/scrambler_58.sv
// -----------------------------------------------------------------------------
// scrambler_58
// Self-synchronous x^58 + x^39 + 1 scrambler, 64 bits per clock.
// Combinational data path, registered 58-bit history.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (state <= SEED)
//   en_i         1 = dat_i is a real block: advance the history
//   dat_i[63:0]  plain payload, bit 0 first
//   dat_o[63:0]  scrambled payload, bit 0 first (valid in the same cycle)
//
// State layout: state_q[k] holds scrambled bit s[n-58+k], so state_q[57] is
// the most recently transmitted bit.
// -----------------------------------------------------------------------------
module scrambler_58
    import tx_gb_pkg::*;
#(
    parameter logic [SCR_W-1:0] SEED = SCR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [WORD_W-1:0] dat_i,
    output logic [WORD_W-1:0] dat_o
);

    // History concatenated with the new bits: index SCR_W+i is output bit i,
    // so s[i-39] and s[i-58] are simply lower indices of the same vector and
    // the serial dependency resolves inside one loop.
    function automatic logic [SCR_W+WORD_W-1:0] scramble(
        input logic [SCR_W-1:0]  st,
        input logic [WORD_W-1:0] d
    );
        logic [SCR_W+WORD_W-1:0] h;
        h = {{WORD_W{1'b0}}, st};
        for (int i = 0; i < WORD_W; i++) begin
            h[SCR_W+i] = d[i] ^ h[SCR_W+i-SCR_TAP_A] ^ h[SCR_W+i-SCR_TAP_B];
        end
        return h;
    endfunction

    logic [SCR_W-1:0]        state_q;
    logic [SCR_W-1:0]        state_d;
    logic [SCR_W+WORD_W-1:0] hist;

    assign hist    = scramble(state_q, dat_i);
    assign dat_o   = hist[SCR_W+WORD_W-1:SCR_W];
    // The new history is the last 58 scrambled bits of this word.
    assign state_d = en_i ? hist[SCR_W+WORD_W-1:WORD_W] : state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/tx_gearbox_66_64.sv
// -----------------------------------------------------------------------------
// tx_gearbox_66_64
// TX 66:64 gearbox. Stage 1 optionally scrambles the payload and registers
// the block; stage 2 packs 66-bit blocks into 64-bit words through a residue
// buffer and flags cadence violations.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_dat[63:0]       block payload, bit 0 first
//   in_sh[1:0]         sync header (01 data, 10 control), never scrambled
//   in_val             block valid (nominally 32 of every 33 cycles)
//   scr_en             1 = scramble payload, 0 = bypass
//   clr_stat           synchronous clear of flags and counters (wins over events)
//   out_dat[63:0]      gearboxed word, bit 0 first
//   out_val            out_dat valid
//   ovf_flag/ovf_cnt   sticky flag / saturating count of dropped blocks
//   unf_flag/unf_cnt   sticky flag / saturating count of empty output cycles
//
// Latency: a block on in_val at cycle N starts appearing on out_dat at N+2.
// -----------------------------------------------------------------------------
module tx_gearbox_66_64
    import tx_gb_pkg::*;
#(
    parameter int               CNT_W    = 16,
    parameter logic [SCR_W-1:0] SCR_SEED = SCR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_dat,
    input  logic [1:0]        in_sh,
    input  logic              in_val,
    input  logic              scr_en,
    input  logic              clr_stat,
    output logic [WORD_W-1:0] out_dat,
    output logic              out_val,
    output logic              ovf_flag,
    output logic              unf_flag,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic [CNT_W-1:0]  unf_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ---------------------------------------------------------------- stage 1
    logic [WORD_W-1:0] scr_dat;
    blk66_t            s1_blk_d;
    blk66_t            s1_blk_q;
    logic              s1_val_q;

    // The history only advances on real blocks that are being scrambled.
    scrambler_58 #(
        .SEED (SCR_SEED)
    ) u_scr (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (scr_en & in_val),
        .dat_i (in_dat),
        .dat_o (scr_dat)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        s1_blk_d     = '0;
        s1_blk_d.sh  = in_sh;
        s1_blk_d.dat = scr_en ? scr_dat : in_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_blk_q <= '0;
            s1_val_q <= 1'b0;
        end else begin
            s1_blk_q <= s1_blk_d;
            s1_val_q <= in_val;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [WORD_W-1:0]   residue_q;
    logic [WORD_W-1:0]   residue_d;
    logic [FILL_W-1:0]   fill_q;
    logic [FILL_W-1:0]   fill_d;
    logic [WORD_W-1:0]   out_dat_q;
    logic [WORD_W-1:0]   out_dat_d;
    logic                out_val_q;
    logic                out_val_d;
    logic                full;
    logic [2*WORD_W-1:0] merged;
    gb_op_e              gb_op;
    logic                ovf_ev;
    logic                unf_ev;

    assign full = (fill_q == FILL_FULL);

    // Residue bits at and above fill_q are always zero, so OR-ing the shifted
    // block in is a plain append. Max extent is 62 + 66 = 128 bits.
    assign merged = {{WORD_W{1'b0}}, residue_q}
                  | ((2*WORD_W)'(s1_blk_q) << fill_q);

    always_comb begin
        gb_op = GB_UNDERRUN;
        if (s1_val_q && !full) begin
            gb_op = GB_PUSH;
        end else if (s1_val_q) begin
            gb_op = GB_OVERRUN;
        end else if (full) begin
            gb_op = GB_FLUSH;
        end
    end

    always_comb begin
        out_dat_d = out_dat_q;
        out_val_d = 1'b0;
        residue_d = residue_q;
        fill_d    = fill_q;
        ovf_ev    = 1'b0;
        unf_ev    = 1'b0;
        case (gb_op)
            GB_PUSH: begin
                out_dat_d = merged[WORD_W-1:0];
                out_val_d = 1'b1;
                residue_d = merged[2*WORD_W-1:WORD_W];
                fill_d    = fill_q + 7'd2;
            end
            GB_FLUSH, GB_OVERRUN: begin
                // Emptying the residue keeps the append-by-OR invariant.
                out_dat_d = residue_q;
                out_val_d = 1'b1;
                residue_d = '0;
                fill_d    = '0;
                ovf_ev    = (gb_op == GB_OVERRUN);
            end
            default: begin
                unf_ev = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the residue buffer is reset, not just the fill count, because
        // its contents are OR-ed straight into the first word after reset.
        if (!rst_n) begin
            residue_q <= '0;
            fill_q    <= '0;
            out_dat_q <= '0;
            out_val_q <= 1'b0;
        end else begin
            residue_q <= residue_d;
            fill_q    <= fill_d;
            out_dat_q <= out_dat_d;
            out_val_q <= out_val_d;
        end
    end

    // ------------------------------------------------------------- statistics
    logic             ovf_flag_q;
    logic             ovf_flag_d;
    logic             unf_flag_q;
    logic             unf_flag_d;
    logic [CNT_W-1:0] ovf_cnt_q;
    logic [CNT_W-1:0] ovf_cnt_d;
    logic [CNT_W-1:0] unf_cnt_q;
    logic [CNT_W-1:0] unf_cnt_d;

    always_comb begin
        ovf_flag_d = ovf_flag_q;
        unf_flag_d = unf_flag_q;
        ovf_cnt_d  = ovf_cnt_q;
        unf_cnt_d  = unf_cnt_q;
        if (clr_stat) begin
            // A same-cycle event is deliberately lost.
            ovf_flag_d = 1'b0;
            unf_flag_d = 1'b0;
            ovf_cnt_d  = '0;
            unf_cnt_d  = '0;
        end else begin
            if (ovf_ev) begin
                ovf_flag_d = 1'b1;
                if (ovf_cnt_q != CNT_MAX) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            end
            if (unf_ev) begin
                unf_flag_d = 1'b1;
                if (unf_cnt_q != CNT_MAX) unf_cnt_d = unf_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag_q <= 1'b0;
            unf_flag_q <= 1'b0;
            ovf_cnt_q  <= '0;
            unf_cnt_q  <= '0;
        end else begin
            ovf_flag_q <= ovf_flag_d;
            unf_flag_q <= unf_flag_d;
            ovf_cnt_q  <= ovf_cnt_d;
            unf_cnt_q  <= unf_cnt_d;
        end
    end

    assign out_dat  = out_dat_q;
    assign out_val  = out_val_q;
    assign ovf_flag = ovf_flag_q;
    assign unf_flag = unf_flag_q;
    assign ovf_cnt  = ovf_cnt_q;
    assign unf_cnt  = unf_cnt_q;

endmodule

// File: tb/tb_tx_gearbox_66_64.sv
// -----------------------------------------------------------------------------
// tb_tx_gearbox_66_64
// Directed stimulus with a bit-serial reference model. The driver pushes the
// expected words into a scoreboard queue; a negedge monitor pops and compares
// every word the DUT marks valid, and checks out_dat holds when it is not.
// -----------------------------------------------------------------------------
module tb_tx_gearbox_66_64;
    import tx_gb_pkg::*;

    localparam int              CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [63:0]       in_dat = '0;
    logic [1:0]        in_sh = '0;
    logic              in_val = 1'b0;
    logic              scr_en = 1'b0;
    logic              clr_stat = 1'b0;
    logic [63:0]       out_dat;
    logic              out_val;
    logic              ovf_flag;
    logic              unf_flag;
    logic [CNT_W-1:0]  ovf_cnt;
    logic [CNT_W-1:0]  unf_cnt;

    tx_gearbox_66_64 #(
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_dat   (in_dat),
        .in_sh    (in_sh),
        .in_val   (in_val),
        .scr_en   (scr_en),
        .clr_stat (clr_stat),
        .out_dat  (out_dat),
        .out_val  (out_val),
        .ovf_flag (ovf_flag),
        .unf_flag (unf_flag),
        .ovf_cnt  (ovf_cnt),
        .unf_cnt  (unf_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    logic [63:0] sb_q[$];
    logic [63:0] last_exp = '0;
    logic [63:0] obs_words[0:63];
    int          obs_n = 0;
    int          inv_obs = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_val) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got word %h expected none", out_dat);
                end else begin
                    last_exp = sb_q.pop_front();
                    check("out_dat", out_dat, last_exp);
                end
                if (obs_n < 64) obs_words[obs_n] = out_dat;
                obs_n++;
            end else begin
                inv_obs++;
                check("out_dat_hold", out_dat, last_exp);
            end
        end
    end

    // ---------------------------------------------------------- reference model
    bit          m_bits[$];
    logic [57:0] m_scr;
    logic        m_prev_v;
    logic [65:0] m_prev_blk;
    int          m_ovf, m_unf, m_inv;
    logic        m_ovf_f, m_unf_f;
    int          s_ovf, s_unf, s_inv;
    logic        s_ovf_f, s_unf_f;

    task automatic model_reset();
        m_bits.delete();
        m_scr      = SCR_SEED_DEF;
        m_prev_v   = 1'b0;
        m_prev_blk = '0;
        m_ovf = 0; m_unf = 0; m_inv = 0;
        m_ovf_f = 1'b0; m_unf_f = 1'b0;
    endtask

    // One clock of the design: consume the block captured last cycle, then
    // capture the inputs currently driven.
    task automatic model_cycle();
        logic [63:0] w;
        logic [63:0] pay;
        logic        ev_o;
        logic        ev_u;
        bit          s;
        s_ovf = m_ovf; s_unf = m_unf; s_inv = m_inv;
        s_ovf_f = m_ovf_f; s_unf_f = m_unf_f;
        ev_o = 1'b0;
        ev_u = 1'b0;
        if (m_prev_v && m_bits.size() == 64) begin
            ev_o = 1'b1;
        end else if (m_prev_v) begin
            for (int i = 0; i < 66; i++) m_bits.push_back(m_prev_blk[i]);
        end
        if (m_bits.size() >= 64) begin
            for (int j = 0; j < 64; j++) w[j] = m_bits.pop_front();
            sb_q.push_back(w);
        end else begin
            ev_u = 1'b1;
            m_inv++;
        end
        if (clr_stat) begin
            m_ovf = 0; m_unf = 0; m_ovf_f = 1'b0; m_unf_f = 1'b0;
        end else begin
            if (ev_o) begin m_ovf_f = 1'b1; if (m_ovf < int'(CNT_MAX)) m_ovf++; end
            if (ev_u) begin m_unf_f = 1'b1; if (m_unf < int'(CNT_MAX)) m_unf++; end
        end
        pay = in_dat;
        if (in_val && scr_en) begin
            for (int i = 0; i < 64; i++) begin
                s      = in_dat[i] ^ m_scr[38] ^ m_scr[57];
                pay[i] = s;
                m_scr  = {m_scr[56:0], s};
            end
        end
        m_prev_v   = in_val;
        m_prev_blk = {pay, in_sh};
    endtask

    // ---------------------------------------------------------------- driver
    task automatic step(input logic v, input logic [63:0] d, input logic [1:0] sh,
                        input logic scr, input logic clr);
        @(posedge clk);
        #1;
        in_val = v; in_dat = d; in_sh = sh; scr_en = scr; clr_stat = clr;
        model_cycle();
    endtask

    task automatic period(input int nval, input int ngap, input logic [63:0] d,
                          input logic scr, input logic alt_sh);
        for (int i = 0; i < nval; i++)
            step(1'b1, d, (alt_sh && i[0]) ? SH_CTRL : SH_DATA, scr, 1'b0);
        for (int i = 0; i < ngap; i++)
            step(1'b0, d, SH_DATA, scr, 1'b0);
    endtask

    // Compare DUT statistics and observed empty cycles with the model as of
    // the previous clock, which is what the registered outputs reflect here.
    task automatic checkpoint(input string tag);
        #5;
        check({tag, "_ovf_cnt"},  64'(ovf_cnt),  64'(s_ovf));
        check({tag, "_unf_cnt"},  64'(unf_cnt),  64'(s_unf));
        check({tag, "_ovf_flag"}, 64'(ovf_flag), 64'(s_ovf_f));
        check({tag, "_unf_flag"}, 64'(unf_flag), 64'(s_unf_f));
        check({tag, "_empty_cycles"}, 64'(inv_obs), 64'(s_inv));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_val = 1'b0; in_dat = '0; in_sh = '0; scr_en = 1'b0; clr_stat = 1'b0;
        #1;
        check("rst_out_val",  64'(out_val),  64'd0);
        check("rst_out_dat",  out_dat,       64'd0);
        check("rst_ovf_flag", 64'(ovf_flag), 64'd0);
        check("rst_unf_flag", 64'(unf_flag), 64'd0);
        check("rst_ovf_cnt",  64'(ovf_cnt),  64'd0);
        check("rst_unf_cnt",  64'(unf_cnt),  64'd0);
        sb_q.delete();
        model_reset();
        last_exp = '0;
        obs_n    = 0;
        inv_obs  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        // Partial cycle between release and the next edge.
        model_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int inv0;

    initial begin
        // Reset, then idle long enough to saturate the underrun counter.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, '0, SH_DATA, 1'b0, 1'b0);
        checkpoint("idle");
        check("idle_unf_sat", 64'(unf_cnt), 64'(CNT_MAX));

        // Bypass stream, 0x1E data blocks; statistics cleared at start-up.
        step(1'b1, 64'h1E, SH_DATA, 1'b0, 1'b1);
        step(1'b1, 64'h1E, SH_DATA, 1'b0, 1'b1);
        checkpoint("start");
        inv0 = inv_obs;
        period(30, 1, 64'h1E, 1'b0, 1'b0);
        for (int p = 0; p < 9; p++) period(32, 1, 64'h1E, 1'b0, 1'b0);
        checkpoint("bypass");
        check("bypass_ovf_zero", 64'(ovf_cnt), 64'd0);
        check("bypass_unf_zero", 64'(unf_cnt), 64'd0);
        check("bypass_no_gap",   64'(inv_obs - inv0), 64'd0);
        check("word0",  obs_words[0],  64'h0000_0000_0000_0079);
        check("word1",  obs_words[1],  64'h0000_0000_0000_01E4);
        check("word31", obs_words[31], 64'h4000_0000_0000_0007);
        check("word32_gap_residue", obs_words[32], 64'h0000_0000_0000_001E);

        // Overrun: 33 back-to-back blocks, then nominal cadence.
        period(33, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
        period(32, 1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
        checkpoint("ovf");
        check("ovf_cnt_one",   64'(ovf_cnt),  64'd1);
        check("ovf_flag_set",  64'(ovf_flag), 64'd1);
        check("ovf_no_gap",    64'(inv_obs - inv0), 64'd0);

        // Underrun: two-cycle gap.
        period(32, 2, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
        period(32, 1, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
        checkpoint("unf");
        check("unf_cnt_one",  64'(unf_cnt), 64'd1);
        check("unf_one_gap",  64'(inv_obs - inv0), 64'd1);

        // Reset mid-period, then 1024 all-zero scrambled blocks from the seed.
        period(10, 0, 64'h5A5A_0000_FFFF_1234, 1'b0, 1'b0);
        do_reset();
        for (int p = 0; p < 32; p++) period(32, 1, 64'h0, 1'b1, 1'b1);
        checkpoint("scr");

        // Clear on the same cycle as an overrun.
        for (int i = 0; i < 33; i++)
            step(1'b1, 64'hDEAD_BEEF_0123_4567, SH_CTRL, 1'b1, 1'b0);
        step(1'b1, 64'hDEAD_BEEF_0123_4567, SH_DATA, 1'b1, 1'b1);
        period(31, 1, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b1);
        checkpoint("clr");
        check("clr_ovf_flag", 64'(ovf_flag), 64'd0);
        check("clr_ovf_cnt",  64'(ovf_cnt),  64'd0);

        // Drain and confirm every expected word was seen.
        for (int i = 0; i < 3; i++) step(1'b0, '0, SH_DATA, 1'b0, 1'b0);
        checkpoint("drain");
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
